instr_fetch: RTL

Instruction fetch stage directly downstream of the program counter register. Takes the current PC, issues one word read at a time to instruction memory over a request/response handshake, and holds the returned instruction for decode under a valid/ready handshake. Drives the PC's next-address input every cycle (hold, +4, or redirect target), handles branch/jump redirects, and detects fetch timeouts and misaligned targets.

---
 rtl/instr_fetch.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/instr_fetch.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : instr_fetch
// Description : Instruction fetch stage. Issues one word read at a time to
//               instruction memory, holds the returned word for decode under
//               a valid/ready handshake, drives the PC next-address input and
//               handles redirects, fetch timeouts and misaligned targets.
// Revision    : 1.0 - initial release
// ============================================================================
module instr_fetch #(
    parameter logic [31:0] NOP_INSTR      = 32'h0000_0013,
    parameter int          TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] current_pc,
    output logic [31:0] next_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        id_valid,
    output logic [31:0] id_instr,
    output logic [31:0] id_pc,
    input  logic        id_ready,
    output logic        fetch_fault
);

    localparam int C_TMO_NEED = $clog2(TIMEOUT_CYCLES + 1);
    localparam int C_TMO_W    = (C_TMO_NEED > 8) ? C_TMO_NEED : 8;
    localparam logic [C_TMO_W-1:0] C_TMO_LAST = C_TMO_W'(TIMEOUT_CYCLES - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_FETCH = 2'd1;
    localparam logic [1:0] S_HOLD  = 2'd2;
    localparam logic [1:0] S_FAULT = 2'd3;

    logic [1:0]         r_state;
    logic [31:0]        r_req_addr;
    logic [31:0]        r_pend_pc;
    logic               r_kill;
    logic [C_TMO_W-1:0] r_tmo_cnt;
    logic               r_id_valid;
    logic [31:0]        r_id_instr;
    logic [31:0]        r_id_pc;

    logic        w_in_fetch;
    logic        w_bad_target;
    logic        w_accept;
    logic        w_tmo_hit;
    logic        w_to_fault;
    logic [31:0] w_seq_pc;

    assign w_in_fetch   = (r_state == S_FETCH);
    assign w_bad_target = redirect && (redirect_pc[1:0] != 2'b00);
    // A response is only kept when no redirect has invalidated it.
    assign w_accept     = w_in_fetch && imem_rvalid && !r_kill && !redirect;
    // Counter reaching its last value with still no response ends the fetch.
    assign w_tmo_hit    = (TIMEOUT_CYCLES != 0) && w_in_fetch && !imem_rvalid &&
                          (r_tmo_cnt == C_TMO_LAST);
    assign w_to_fault   = (r_state != S_FAULT) && (w_bad_target || w_tmo_hit);
    assign w_seq_pc     = r_req_addr + 32'd4;

    assign imem_req    = w_in_fetch;
    assign imem_addr   = w_in_fetch ? r_req_addr : 32'd0;
    assign id_valid    = r_id_valid;
    assign id_instr    = r_id_instr;
    assign id_pc       = r_id_pc;
    assign fetch_fault = (r_state == S_FAULT);

    // Next-address selection for the PC register: hold unless advancing or redirecting.
    always_comb begin
        next_pc = current_pc;
        if (reset && !w_to_fault) begin
            case (r_state)
                S_IDLE: begin
                    if (redirect) next_pc = redirect_pc;
                end
                S_FETCH: begin
                    if (w_accept)      next_pc = w_seq_pc;
                    else if (redirect) next_pc = redirect_pc;
                end
                S_HOLD: begin
                    if (redirect) next_pc = redirect_pc;
                end
                default: ;
            endcase
        end
    end

    // Fetch state machine, request address tracking and decode holding register.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state    <= S_IDLE;
            r_req_addr <= 32'd0;
            r_pend_pc  <= 32'd0;
            r_kill     <= 1'b0;
            r_tmo_cnt  <= '0;
            r_id_valid <= 1'b0;
            r_id_instr <= NOP_INSTR;
            r_id_pc    <= 32'd0;
        end else if (w_to_fault) begin
            r_state    <= S_FAULT;
            r_kill     <= 1'b0;
            r_id_valid <= 1'b0;
            r_id_instr <= NOP_INSTR;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_req_addr <= redirect ? redirect_pc : current_pc;
                    r_tmo_cnt  <= '0;
                    r_state    <= S_FETCH;
                end
                S_FETCH: begin
                    if (imem_rvalid) begin
                        r_tmo_cnt <= '0;
                        if (!r_kill && !redirect) begin
                            r_id_valid <= 1'b1;
                            r_id_instr <= imem_rdata;
                            r_id_pc    <= r_req_addr;
                            r_req_addr <= w_seq_pc;
                            r_state    <= S_HOLD;
                        end else begin
                            // Stale or redirected response: drop it and re-request.
                            r_req_addr <= redirect ? redirect_pc : r_pend_pc;
                            r_kill     <= 1'b0;
                        end
                    end else begin
                        r_tmo_cnt <= r_tmo_cnt + 1'b1;
                        if (redirect) begin
                            // Outstanding request cannot be cancelled; mark it stale.
                            r_kill    <= 1'b1;
                            r_pend_pc <= redirect_pc;
                        end
                    end
                end
                S_HOLD: begin
                    if (redirect) begin
                        r_id_valid <= 1'b0;
                        r_id_instr <= NOP_INSTR;
                        r_req_addr <= redirect_pc;
                        r_tmo_cnt  <= '0;
                        r_state    <= S_FETCH;
                    end else if (id_ready) begin
                        r_id_valid <= 1'b0;
                        r_id_instr <= NOP_INSTR;
                        r_tmo_cnt  <= '0;
                        r_state    <= S_FETCH;
                    end
                end
                default: begin
                    r_state <= S_FAULT;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
